// File: rtl/serial_mag_comparator.sv
// Sequential WIDTH-bit magnitude comparator that walks 2-bit slices MSB-first
// through an external combinational 2-bit comparator and posts a registered result.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err,
  output logic             a1,
  output logic             a0,
  output logic             b1,
  output logic             b0,
  input  logic             cg,
  input  logic             ce,
  input  logic             cl
);

  localparam int S  = WIDTH / 2;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [IW-1:0]     idx_r;
  logic [S-1:0][1:0] a_sl_s;
  logic [S-1:0][1:0] b_sl_s;
  logic              code_ok_s;

  function automatic logic one_hot3(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

  assign a_sl_s    = a_r;
  assign b_sl_s    = b_r;
  assign code_ok_s = one_hot3(cg, ce, cl);

  // Slice presented to the comparator; forced to zero outside RUN.
  always_comb begin
    a1 = 1'b0;
    a0 = 1'b0;
    b1 = 1'b0;
    b0 = 1'b0;
    if (state_r == RUN) begin
      {a1, a0} = a_sl_s[idx_r];
      {b1, b0} = b_sl_s[idx_r];
    end else begin
      {a1, a0} = 2'b00;
      {b1, b0} = 2'b00;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx_r   <= LAST_IDX;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (!code_ok_s) begin
            err <= 1'b1;
          end
          // Anything that is neither g nor l (including the all-low code)
          // advances like an equal slice, so the walk always ends in S cycles.
          if (cg) begin
            gt      <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (cl) begin
            lt      <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (idx_r == '0) begin
            eq      <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            idx_r <= idx_r - 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Sequential N-bit magnitude comparator built around the team's combinational 2-bit comparator.
- Latches two WIDTH-bit operands on a start handshake.
- Presents one 2-bit slice per cycle to an external 2-bit comparator instance, MSB slice first.
- Consumes that comparator's g/e/l outputs and stops at the first unequal slice.
- Reports a registered gt/eq/lt result with a one-cycle done pulse.
- Sits both upstream of the 2-bit comparator (drives its inputs) and downstream of it (consumes its outputs).

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; number of slices S = WIDTH/2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a comparison; accepted only when busy=0
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse when a result is posted
gt  output  1  registered result A>B
eq  output  1  registered result A==B
lt  output  1  registered result A<B
err  output  1  sticky flag: comparator returned a non-one-hot g/e/l code
a1  output  1  slice bit 1 of A, to comparator
a0  output  1  slice bit 0 of A, to comparator
b1  output  1  slice bit 1 of B, to comparator
b0  output  1  slice bit 0 of B, to comparator
cg  input  1  comparator g (slice A>B)
ce  input  1  comparator e (slice A==B)
cl  input  1  comparator l (slice A<B)

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, gt=0, eq=0, lt=0, err=0; slice index=0; a1/a0/b1/b0=0.
- States: IDLE, RUN.
- IDLE:
  - a1/a0/b1/b0 driven 0.
  - On a clock edge with start=1: latch a->a_q and b->b_q; index=S-1; clear gt/eq/lt; busy=1; go to RUN.
- RUN:
  - Slice outputs are combinational from registers: {a1,a0}=a_q[2*index+1:2*index], {b1,b0}=b_q[2*index+1:2*index].
  - The comparator is combinational; cg/ce/cl are sampled at each RUN edge.
  - Decode priority is cg > cl > ce.
  - cg=1: gt=1, done=1, busy=0, go to IDLE.
  - else cl=1: lt=1, done=1, busy=0, go to IDLE.
  - else ce=1 and index=0: eq=1, done=1, busy=0, go to IDLE.
  - else ce=1: index decrements; stay in RUN.
  - All three low: treated as not-equal-decidable; err=1 and the cycle behaves as the ce=1 case. This bounds termination at S cycles.
  - Any code that is not exactly one-hot sets err=1. err is sticky until rst.
- Latency:
  - k cycles from the start-accept edge to the edge that raises done.
  - k = 1-based position (from MSB) of the first unequal slice, or S if all slices are equal.
  - Maximum latency is S.
- done: high exactly one cycle, then returns to 0.
- gt/eq/lt: exactly one is high after a completed comparison. They hold until the next accepted start, which clears them on that edge.
- start while busy=1: ignored. Operands are not re-latched and the in-flight comparison is unaffected.
- start during the done cycle: accepted, since busy=0 in that cycle.
- Back-to-back comparisons: permitted.
- Operand change after accept: changes on a/b have no effect until the next accept.
- rst mid-RUN: immediate abort to the reset values. No done pulse is produced.
- WIDTH=2: S=1; every comparison completes in 1 cycle.

Test Plan:
- WIDTH=8, A=0xB4, B=0x4B, start pulse -> first RUN slice a=10, b=01; done after 1 cycle; gt=1, eq=0, lt=0; busy low in done cycle.
- A=0x5A, B=0x5A -> 4 RUN cycles, slices 01/01, 01/01, 10/10, 10/10; done on 4th edge; eq=1.
- A=0x12, B=0x13 -> done after 4 cycles with lt=1. Then start with A=0xFF, B=0x00 in the done cycle -> accepted; gt=1 one cycle later; lt cleared at accept.
- A=0x40, B=0x00 start, then start with A=0x00, B=0xFF during busy -> second start ignored; result gt=1 for the original operands after 1 cycle.
- A=0x55, B=0x56, assert rst after 2 RUN cycles -> all outputs 0 immediately, no done. Restart with A=0x55, B=0x56 -> lt=1 after 4 cycles.
- Bench overrides the comparator so cg=ce=1 on the first slice -> gt=1, done after 1 cycle, err=1; err stays 1 through a following clean comparison until rst.
